data_memory_ctrl: RTL and testbench

DATA_MEMORY_CTRL -- requirements
Module: data_memory_ctrl

---
 rtl/data_memory_ctrl.sv | 147 ++++++++++++++
 tb/tb_data_memory_ctrl.sv | 285 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/data_memory_ctrl.sv
// -----------------------------------------------------------------------------
// data_memory_ctrl
//
// Line-oriented data memory with a fixed, parameterised access latency. A
// request is captured when the controller is idle, waits out LATENCY cycles,
// and then completes with a one-cycle ack. Reads return the whole 256-bit line
// on data_o; writes commit the captured line at the end of the ack cycle.
// The memory array has no reset so it survives a controller reset.
//
// Parameters:
//   LATENCY  cycles from request acceptance to ack (2..255)
//   DEPTH    number of 256-bit lines (power of two)
//
// Ports:
//   clk_i     in   1    clock, rising edge
//   rst_i     in   1    asynchronous reset, active low
//   enable_i  in   1    request valid, held with the request fields until ack
//   write_i   in   1    1 = line write, 0 = line read
//   addr_i    in   32   byte address, line index taken from bits above [4:0]
//   data_i    in   256  write line data
//   ack_o     out  1    one-cycle completion pulse
//   data_o    out  256  registered read line data
//   busy_o    out  1    request in progress
// -----------------------------------------------------------------------------
module data_memory_ctrl #(
  parameter int LATENCY = 10,
  parameter int DEPTH   = 512
) (
  input  logic         clk_i,
  input  logic         rst_i,
  input  logic         enable_i,
  input  logic         write_i,
  input  logic [31:0]  addr_i,
  input  logic [255:0] data_i,
  output logic         ack_o,
  output logic [255:0] data_o,
  output logic         busy_o
);

  localparam int IDX_W = $clog2(DEPTH);

  // The wait counter starts at 0 on the first WAIT cycle, so the final WAIT
  // cycle is LATENCY-2; together with the accept edge and the ACK cycle this
  // puts ack_o exactly LATENCY cycles after the request was sampled.
  localparam logic [7:0] LAST_WAIT = 8'(LATENCY - 2);

  typedef enum logic [1:0] {
    IDLE,
    WAIT,
    ACK
  } state_t;

  state_t             state_q, state_d;
  logic [7:0]         count_q, count_d;
  logic [IDX_W-1:0]   reqIndex_q, reqIndex_d;
  logic               reqWrite_q, reqWrite_d;
  logic [255:0]       reqData_q, reqData_d;
  logic [255:0]       readData_q, readData_d;

  logic [255:0]       mem [DEPTH];

  // Byte offset and address bits above the line index alias onto the same
  // line, so they are deliberately dropped.
  logic               unusedAddrBits;
  assign unusedAddrBits = ^{addr_i[31:5+IDX_W], addr_i[4:0]};

  // Next-state logic. Request fields are only sampled in IDLE, so anything
  // the requester does to addr/write/data afterwards has no effect. Only
  // enable_i is watched during WAIT, and only to detect an abort.
  always_comb begin
    state_d    = state_q;
    count_d    = count_q;
    reqIndex_d = reqIndex_q;
    reqWrite_d = reqWrite_q;
    reqData_d  = reqData_q;
    readData_d = readData_q;

    case (state_q)
      IDLE: begin
        if (enable_i) begin
          state_d    = WAIT;
          count_d    = '0;
          reqIndex_d = addr_i[5 +: IDX_W];
          reqWrite_d = write_i;
          reqData_d  = data_i;
        end
      end

      WAIT: begin
        // An abort wins even on the last wait cycle: no ack and no read
        // data update once the requester has withdrawn.
        if (!enable_i) begin
          state_d = IDLE;
        end else if (count_q == LAST_WAIT) begin
          state_d = ACK;
          if (!reqWrite_q) begin
            readData_d = mem[reqIndex_q];
          end
        end else begin
          count_d = count_q + 8'd1;
        end
      end

      ACK: begin
        state_d = IDLE;
      end

      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // Control and request registers. Reset drops any request in flight, which
  // also keeps a pending write from ever reaching the array.
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      state_q    <= IDLE;
      count_q    <= '0;
      reqIndex_q <= '0;
      reqWrite_q <= 1'b0;
      reqData_q  <= '0;
      readData_q <= '0;
    end else begin
      state_q    <= state_d;
      count_q    <= count_d;
      reqIndex_q <= reqIndex_d;
      reqWrite_q <= reqWrite_d;
      reqData_q  <= reqData_d;
      readData_q <= readData_d;
    end
  end

  // Memory array, intentionally without reset. A write commits on the edge
  // that ends the ACK cycle; reset forces the state out of ACK asynchronously,
  // so a write cancelled by reset never lands.
  always_ff @(posedge clk_i) begin
    if (state_q == ACK && reqWrite_q) begin
      mem[reqIndex_q] <= reqData_q;
    end
  end

  assign ack_o  = (state_q == ACK);
  assign busy_o = (state_q != IDLE);
  assign data_o = readData_q;

endmodule

// File: tb/tb_data_memory_ctrl.sv
// -----------------------------------------------------------------------------
// tb_data_memory_ctrl
//
// Self-checking bench for data_memory_ctrl. The main instance (LATENCY=10,
// DEPTH=512) is compared every cycle against a timing-based request model:
// a request accepted at edge a is busy for LATENCY cycles, acks in its last
// one, and a write lands at the following edge. Directed cases pin the model
// with literal values; a second instance with LATENCY=2 checks the minimum
// latency and the back-to-back ack cadence.
// -----------------------------------------------------------------------------
module tb_data_memory_ctrl;

  localparam int LAT = 10;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;

  logic         enable = 1'b0;
  logic         write = 1'b0;
  logic [31:0]  addr = '0;
  logic [255:0] wdata = '0;
  logic         ack;
  logic         busy;
  logic [255:0] rdata;

  logic         en2 = 1'b0;
  logic         wr2 = 1'b0;
  logic [31:0]  addr2 = '0;
  logic [255:0] wdata2 = '0;
  logic         ack2;
  logic         busy2;
  logic [255:0] rdata2;

  int tests = 0;
  int failed = 0;
  int cyc = 0;
  bit checkOn = 1'b0;

  data_memory_ctrl #(.LATENCY(LAT), .DEPTH(512)) dut (
    .clk_i    (clk),
    .rst_i    (rst_n),
    .enable_i (enable),
    .write_i  (write),
    .addr_i   (addr),
    .data_i   (wdata),
    .ack_o    (ack),
    .data_o   (rdata),
    .busy_o   (busy)
  );

  data_memory_ctrl #(.LATENCY(2), .DEPTH(16)) dut2 (
    .clk_i    (clk),
    .rst_i    (rst_n),
    .enable_i (en2),
    .write_i  (wr2),
    .addr_i   (addr2),
    .data_i   (wdata2),
    .ack_o    (ack2),
    .data_o   (rdata2),
    .busy_o   (busy2)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Reference model: a request is described by the edge it was accepted on;
  // everything else follows from how many edges have passed since then.
  typedef struct packed {
    bit           active;
    int           start;
    int           edges;
    logic [8:0]   idx;
    bit           wr;
    logic [255:0] data;
    logic [255:0] rdData;
  } model_t;

  model_t       m = '0;
  logic [255:0] memModel [512];
  logic         expAck;
  logic         expBusy;

  function automatic model_t modelNext(model_t cur, logic en, logic wr,
                                       logic [31:0] a, logic [255:0] d);
    model_t nxt = cur;
    int k;
    nxt.edges = cur.edges + 1;
    k = nxt.edges - cur.start;
    if (!cur.active) begin
      if (en) begin
        nxt.active = 1'b1;
        nxt.start  = nxt.edges;
        nxt.idx    = a[13:5];
        nxt.wr     = wr;
        nxt.data   = d;
      end
    end else if (k < LAT) begin
      if (!en) begin
        nxt.active = 1'b0;
      end else if (k == LAT - 1 && !cur.wr) begin
        nxt.rdData = memModel[cur.idx];
      end
    end else begin
      nxt.active = 1'b0;
    end
    return nxt;
  endfunction

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m <= '0;
    end else begin
      m <= modelNext(m, enable, write, addr, wdata);
      if (m.active && m.wr && (m.edges + 1 - m.start == LAT)) begin
        memModel[m.idx] <= m.data;
      end
    end
  end

  assign expBusy = m.active;
  assign expAck  = m.active && (m.edges - m.start == LAT - 1);

  task automatic checkOutput(input string name, input logic [255:0] act,
                             input logic [255:0] exp);
    tests++;
    if (act !== exp) begin
      failed++;
      $display("[TB] FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  // Per-cycle comparison of the main instance against the model.
  always @(negedge clk) begin
    if (checkOn) begin
      checkOutput("ack", 256'(ack), 256'(expAck));
      checkOutput("busy", 256'(busy), 256'(expBusy));
      checkOutput("dataOut", rdata, m.rdData);
    end
  end

  // Drives one request on the main instance and waits for ack or abort.
  task automatic applyStimulus(input bit wr, input logic [31:0] a,
                               input logic [255:0] d, input int abortAt,
                               input bit scramble, input bit holdAfter,
                               output int ackCnt, output int busyCnt,
                               output int ackCyc);
    ackCnt  = 0;
    busyCnt = 0;
    ackCyc  = -1;
    @(negedge clk);
    enable = 1'b1;
    write  = wr;
    addr   = a;
    wdata  = d;
    for (int c = 1; c <= 40; c++) begin
      @(negedge clk);
      if (busy) busyCnt++;
      if (ack) begin
        ackCnt = c;
        ackCyc = cyc;
        if (!holdAfter) enable = 1'b0;
        return;
      end
      if (abortAt == c) begin
        enable = 1'b0;
        return;
      end
      if (scramble) begin
        addr  = $urandom;
        wdata = {8{$urandom}};
        write = 1'($urandom_range(0, 1));
      end
    end
    tests++;
    failed++;
    $display("[TB] FAIL ackTimeout: no ack after 40 cycles, expected one after %0d", LAT);
    enable = 1'b0;
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation did not finish");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    int ac, bc, t1, t2;
    logic [255:0] v;
    logic [255:0] pat2;
    bit hold;
    bit wr;
    logic [31:0] a;
    int ab;

    for (int i = 0; i < 512; i++) begin
      v = {8{$urandom}};
      dut.mem[i]  = v;
      memModel[i] = v;
    end
    dut.mem[3]  = {32{8'hA5}};
    memModel[3] = {32{8'hA5}};
    dut.mem[4]  = 256'h4444;
    memModel[4] = 256'h4444;
    dut.mem[7]  = 256'hDEAD_BEEF;
    memModel[7] = 256'hDEAD_BEEF;
    pat2 = {16{16'hC0FE}};
    dut2.mem[5] = pat2;

    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    checkOutput("resetAck", 256'(ack), 256'd0);
    checkOutput("resetBusy", 256'(busy), 256'd0);
    checkOutput("resetData", rdata, 256'd0);
    checkOn = 1'b1;

    // Read of preloaded line 3.
    applyStimulus(1'b0, 32'h60, '0, 0, 1'b0, 1'b0, ac, bc, t1);
    checkOutput("readLatency", 256'(ac), 256'd10);
    checkOutput("readBusyCycles", 256'(bc), 256'd10);
    checkOutput("readData", rdata, {32{8'hA5}});

    // Write then aliased read, back to back.
    applyStimulus(1'b1, 32'h0000_0040, 256'h1234, 0, 1'b0, 1'b1, ac, bc, t1);
    applyStimulus(1'b0, 32'h0000_4040, '0, 0, 1'b0, 1'b0, ac, bc, t2);
    checkOutput("aliasRead", rdata, 256'h1234);
    checkOutput("b2bSpacing", 256'(t2 - t1), 256'd11);

    // Abort on the 5th WAIT cycle.
    applyStimulus(1'b1, 32'h80, 256'hBAD, 5, 1'b0, 1'b0, ac, bc, t1);
    checkOutput("abortNoAck", 256'(ac), 256'd0);
    @(negedge clk);
    checkOutput("abortIdle", 256'(busy), 256'd0);
    checkOutput("abortLine4", dut.mem[4], 256'h4444);

    // Inputs scrambled during WAIT must not affect the write.
    applyStimulus(1'b1, 32'h1A0, 256'h5151, 0, 1'b1, 1'b0, ac, bc, t1);
    applyStimulus(1'b0, 32'h1A0, '0, 0, 1'b0, 1'b0, ac, bc, t1);
    checkOutput("stableWrite", rdata, 256'h5151);

    // Reset during the ACK cycle of a write.
    applyStimulus(1'b1, 32'hE0, 256'h7777, 0, 1'b0, 1'b0, ac, bc, t1);
    #2 rst_n = 1'b0;
    #1;
    checkOutput("rstAck", 256'(ack), 256'd0);
    checkOutput("rstBusy", 256'(busy), 256'd0);
    checkOutput("rstData", rdata, 256'd0);
    @(negedge clk);
    rst_n = 1'b1;
    checkOutput("rstNoCommit", dut.mem[7], 256'hDEAD_BEEF);

    // Randomised traffic over a small set of lines, with aliasing upper bits.
    for (int n = 0; n < 40; n++) begin
      wr = 1'($urandom_range(0, 1));
      a = $urandom;
      a[13:5] = 9'($urandom_range(0, 15));
      ab = ($urandom_range(0, 4) == 0) ? int'($urandom_range(1, LAT - 1)) : 0;
      hold = (n < 39) && ($urandom_range(0, 1) == 1);
      applyStimulus(wr, a, {8{$urandom}}, ab, 1'($urandom_range(0, 1)), hold,
                    ac, bc, t1);
    end
    repeat (2) @(negedge clk);
    for (int i = 0; i < 16; i++) begin
      checkOutput($sformatf("memLine%0d", i), dut.mem[i], memModel[i]);
    end

    // LATENCY=2 instance: continuous read of line 5.
    @(negedge clk);
    en2   = 1'b1;
    wr2   = 1'b0;
    addr2 = 32'hA0;
    for (int i = 1; i <= 9; i++) begin
      @(negedge clk);
      checkOutput($sformatf("lat2Ack%0d", i), 256'(ack2), 256'(i % 3 == 2));
      checkOutput($sformatf("lat2Busy%0d", i), 256'(busy2), 256'(i % 3 != 0));
      if (i % 3 == 2) checkOutput("lat2Data", rdata2, pat2);
    end
    en2 = 1'b0;
    repeat (2) @(negedge clk);

    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule
